// File: rtl/instruction_fetcher_pkg.sv
// Shared types and constants for the per-warp instruction fetch stage.
// Holds the fetcher state encoding, the instruction word type and the
// default address/instruction widths used by the interface and the top.
package instruction_fetcher_pkg;

    // Default program-memory word address width (PC width).
    localparam int DEFAULT_PROGRAM_ADDR_WIDTH = 8;

    // Width of one instruction word; instruction_t is built from it.
    localparam int DEFAULT_INSTRUCTION_WIDTH = 32;

    // Raw state encodings, kept as plain constants for legacy tooling that
    // reads the debug state bus as a number.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQUEST = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        REQUEST = ST_REQUEST,
        WAIT    = ST_WAIT,
        DONE    = ST_DONE
    } fetcher_state_t;

    // An all-zero instruction decodes as a no-op downstream.
    typedef logic [DEFAULT_INSTRUCTION_WIDTH-1:0] instruction_t;

endpackage

// File: rtl/instruction_fetcher_if.sv
// Bundle of the scheduler, program-memory and decoder signals of the
// instruction fetcher. The master modport is the fetcher's view; the slave
// modport is the view of the surrounding scheduler/memory/decoder.
// Optional macro FETCHER_STATS_EN adds the fetch_count / stall_cycles
// statistics outputs.
interface instruction_fetcher_if
    import instruction_fetcher_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_PROGRAM_ADDR_WIDTH,
    parameter int INSTR_W = DEFAULT_INSTRUCTION_WIDTH
);

    // Scheduler request side
    logic               fetch_start;
    logic [ADDR_W-1:0]  pc;
    logic               fetch_flush;
    logic               instruction_consumed;

    // Program-memory read port
    logic               mem_read_valid;
    logic [ADDR_W-1:0]  mem_read_address;
    logic               mem_read_ready;
    logic               mem_read_data_valid;
    logic [INSTR_W-1:0] mem_read_data;

    // Decoder / debug side
    instruction_t       instruction;
    logic               instruction_valid;
    fetcher_state_t     fetcher_state;

`ifdef FETCHER_STATS_EN
    logic [31:0]        fetch_count;
    logic [31:0]        stall_cycles;

    modport master (
        input  fetch_start, pc, fetch_flush, instruction_consumed,
        output mem_read_valid, mem_read_address,
        input  mem_read_ready, mem_read_data_valid, mem_read_data,
        output instruction, instruction_valid, fetcher_state,
        output fetch_count, stall_cycles
    );

    modport slave (
        output fetch_start, pc, fetch_flush, instruction_consumed,
        input  mem_read_valid, mem_read_address,
        output mem_read_ready, mem_read_data_valid, mem_read_data,
        input  instruction, instruction_valid, fetcher_state,
        input  fetch_count, stall_cycles
    );
`else
    modport master (
        input  fetch_start, pc, fetch_flush, instruction_consumed,
        output mem_read_valid, mem_read_address,
        input  mem_read_ready, mem_read_data_valid, mem_read_data,
        output instruction, instruction_valid, fetcher_state
    );

    modport slave (
        output fetch_start, pc, fetch_flush, instruction_consumed,
        input  mem_read_valid, mem_read_address,
        output mem_read_ready, mem_read_data_valid, mem_read_data,
        input  instruction, instruction_valid, fetcher_state
    );
`endif

endinterface

// File: rtl/instruction_fetcher.sv
// Per-warp instruction fetch stage feeding the decoder.
// A scheduler start issues one program-memory read at the given PC; the
// returned word is held with a valid flag until the scheduler consumes it.
// Supports flush (the outstanding read is still completed but its data is
// dropped) and back-to-back consume+start from DONE without an IDLE bubble.
// All outputs come straight from registers.
// Optional macro FETCHER_STATS_EN adds saturating fetch_count and
// stall_cycles counters, cleared only by reset.
module instruction_fetcher
    import instruction_fetcher_pkg::*;
#(
    parameter int PROGRAM_ADDR_WIDTH = DEFAULT_PROGRAM_ADDR_WIDTH,
    parameter int INSTRUCTION_WIDTH  = DEFAULT_INSTRUCTION_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    instruction_fetcher_if.master bus
);

    fetcher_state_t                r_state;
    logic                          r_discard;
    logic                          r_mem_read_valid;
    logic [PROGRAM_ADDR_WIDTH-1:0] r_mem_read_address;
    instruction_t                  r_instruction;
    logic                          r_instruction_valid;

    logic [INSTRUCTION_WIDTH-1:0]  w_mem_read_data;
    logic                          w_drop;
    logic                          w_response;
    logic                          w_capture;

    assign w_mem_read_data = bus.mem_read_data;

    // A response is dropped if a flush was seen earlier or arrives with it.
    assign w_drop = r_discard | bus.fetch_flush;

    // Response accepted in REQUEST only together with ready; in WAIT alone.
    assign w_response = ((r_state == REQUEST) && bus.mem_read_ready && bus.mem_read_data_valid)
                      || ((r_state == WAIT) && bus.mem_read_data_valid);

    assign w_capture = w_response & ~w_drop;

    // Fetch state machine, memory request and held-instruction registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state             <= IDLE;
            r_discard           <= 1'b0;
            r_mem_read_valid    <= 1'b0;
            r_mem_read_address  <= '0;
            r_instruction       <= '0;
            r_instruction_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.fetch_start && !bus.fetch_flush) begin
                        r_mem_read_address <= bus.pc;
                        r_mem_read_valid   <= 1'b1;
                        r_state            <= REQUEST;
                    end
                end

                REQUEST: begin
                    // Flush never retracts the request; it only marks the
                    // eventual response for discard.
                    if (bus.fetch_flush) begin
                        r_discard <= 1'b1;
                    end
                    if (bus.mem_read_ready) begin
                        r_mem_read_valid <= 1'b0;
                        if (!bus.mem_read_data_valid) begin
                            r_state <= WAIT;
                        end
                    end
                    if (w_response) begin
                        if (w_drop) begin
                            r_discard <= 1'b0;
                            r_state   <= IDLE;
                        end else begin
                            r_instruction       <= w_mem_read_data;
                            r_instruction_valid <= 1'b1;
                            r_state             <= DONE;
                        end
                    end
                end

                WAIT: begin
                    if (bus.fetch_flush) begin
                        r_discard <= 1'b1;
                    end
                    if (w_response) begin
                        if (w_drop) begin
                            r_discard <= 1'b0;
                            r_state   <= IDLE;
                        end else begin
                            r_instruction       <= w_mem_read_data;
                            r_instruction_valid <= 1'b1;
                            r_state             <= DONE;
                        end
                    end
                end

                DONE: begin
                    // Flush wins over consume and start; a start without a
                    // consume is ignored so the held word is never lost.
                    if (bus.fetch_flush) begin
                        r_instruction_valid <= 1'b0;
                        r_state             <= IDLE;
                    end else if (bus.instruction_consumed) begin
                        r_instruction_valid <= 1'b0;
                        if (bus.fetch_start) begin
                            r_mem_read_address <= bus.pc;
                            r_mem_read_valid   <= 1'b1;
                            r_state            <= REQUEST;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_read_valid    = r_mem_read_valid;
    assign bus.mem_read_address  = r_mem_read_address;
    assign bus.instruction       = r_instruction;
    assign bus.instruction_valid = r_instruction_valid;
    assign bus.fetcher_state     = r_state;

`ifdef FETCHER_STATS_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_cycles;

    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == '1) ? value : value + 32'd1;
    endfunction

    // Saturating statistics: captured instructions and memory stall cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_fetch_count  <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_capture) begin
                r_fetch_count <= sat_inc32(r_fetch_count);
            end
            if ((r_state == REQUEST) || (r_state == WAIT)) begin
                r_stall_cycles <= sat_inc32(r_stall_cycles);
            end
        end
    end

    assign bus.fetch_count  = r_fetch_count;
    assign bus.stall_cycles = r_stall_cycles;
`endif

endmodule
